// File: rtl/excp_arb.sv
// Commit-side exception arbiter: ranks the causes of a retiring instruction and sends one csr_bus pulse to the CSR file.
// Latency: transfer edge -> csr_bus for 1 cycle -> redirect_valid the cycle after, if the CSR file jumps.
// Backpressure: in_ready is low outside IDLE; flush and redirect are held until fetch takes the redirect.
module excp_arb #(
  parameter int CSR_BUS_WD = 82
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [31:0]           i_in_pc,
  input  logic [4:0]            i_in_flags,   // {adef, ine, sys, brk, ale}
  input  logic [31:0]           i_in_badv,
  input  logic                  i_in_ertn,
  input  logic                  i_have_intrpt,
  output logic [CSR_BUS_WD-1:0] o_csr_bus,
  input  logic                  i_excp_jump,
  input  logic [31:0]           i_excp_pc,
  output logic                  o_flush,
  output logic                  o_redirect_valid,
  output logic [31:0]           o_redirect_pc,
  input  logic                  i_redirect_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // r_live holds in_ready low until the first edge after reset is released
  logic        r_live;
  logic        r_int_pend;
  logic        r_is_etrn;
  logic        r_in_excp;
  logic [5:0]  r_ecode;
  logic [31:0] r_era;
  logic        r_use_badv;
  logic [31:0] r_badv;
  logic [31:0] r_redirect_pc;

  logic        w_xfer;
  logic        w_int;
  logic        w_any;
  logic [5:0]  w_ecode;
  logic        w_use_badv;

  assign w_xfer = i_in_valid & o_in_ready;
  assign w_int  = r_int_pend | i_have_intrpt;
  assign w_any  = w_int | (|i_in_flags);

  // Fixed-priority cause selection: INT > ADEF > INE > SYS > BRK > ALE
  always_comb begin
    w_ecode    = 6'h00;
    w_use_badv = 1'b0;
    if (w_int) begin
      w_ecode = 6'h00;
    end else if (i_in_flags[4]) begin
      w_ecode    = 6'h08;
      w_use_badv = 1'b1;
    end else if (i_in_flags[3]) begin
      w_ecode = 6'h0D;
    end else if (i_in_flags[2]) begin
      w_ecode = 6'h0B;
    end else if (i_in_flags[1]) begin
      w_ecode = 6'h0C;
    end else if (i_in_flags[0]) begin
      w_ecode    = 6'h09;
      w_use_badv = 1'b1;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; a clean retire with no interrupt leaves the FSM in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_xfer && (w_any || i_in_ertn)) w_next = ISSUE;
      ISSUE:    w_next = i_excp_jump ? REDIRECT : IDLE;
      REDIRECT: if (i_redirect_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; csr_bus is only non-zero in ISSUE
  always_comb begin
    o_in_ready       = (r_state == IDLE) && r_live;
    o_flush          = (r_state == ISSUE) || (r_state == REDIRECT);
    o_redirect_valid = (r_state == REDIRECT);
    o_csr_bus        = '0;
    if (r_state == ISSUE)
      o_csr_bus = {r_is_etrn, r_in_excp, r_ecode, 9'd0, r_era, r_use_badv, r_badv};
  end

  assign o_redirect_pc = r_redirect_pc;

  // Cause fields, sticky interrupt and redirect target
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live        <= 1'b0;
      r_int_pend    <= 1'b0;
      r_is_etrn     <= 1'b0;
      r_in_excp     <= 1'b0;
      r_ecode       <= 6'h00;
      r_era         <= 32'd0;
      r_use_badv    <= 1'b0;
      r_badv        <= 32'd0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_live <= 1'b1;
      // An interrupt rides on the next transferred instruction, which consumes it
      if (w_xfer && w_int) r_int_pend <= 1'b0;
      else                 r_int_pend <= r_int_pend | i_have_intrpt;
      if (w_xfer && w_any) begin
        r_is_etrn  <= 1'b0;
        r_in_excp  <= 1'b1;
        r_ecode    <= w_ecode;
        r_era      <= i_in_pc;
        r_use_badv <= w_use_badv;
        r_badv     <= w_use_badv ? i_in_badv : 32'd0;
      end else if (w_xfer && i_in_ertn) begin
        r_is_etrn  <= 1'b1;
        r_in_excp  <= 1'b0;
        r_ecode    <= 6'h00;
        r_era      <= i_in_pc;
        r_use_badv <= 1'b0;
        r_badv     <= 32'd0;
      end
      if (r_state == ISSUE && i_excp_jump) r_redirect_pc <= i_excp_pc;
    end
  end

endmodule

// File: tb/tb_excp_arb.sv
module tb_excp_arb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_flags;
  logic [31:0] in_badv;
  logic        in_ertn;
  logic        have_intrpt;
  logic [81:0] csr_bus;
  logic        excp_jump;
  logic [31:0] excp_pc;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] F_ADEF = 5'b10000;
  localparam logic [4:0] F_INE  = 5'b01000;
  localparam logic [4:0] F_SYS  = 5'b00100;
  localparam logic [4:0] F_BRK  = 5'b00010;
  localparam logic [4:0] F_ALE  = 5'b00001;

  excp_arb #(.CSR_BUS_WD(82)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_in_pc          (in_pc),
    .i_in_flags       (in_flags),
    .i_in_badv        (in_badv),
    .i_in_ertn        (in_ertn),
    .i_have_intrpt    (have_intrpt),
    .o_csr_bus        (csr_bus),
    .i_excp_jump      (excp_jump),
    .i_excp_pc        (excp_pc),
    .o_flush          (flush),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .i_redirect_ready (redirect_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [81:0] got, input logic [81:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [81:0] bus(input logic etrn, input logic excp, input logic [5:0] ec,
                                      input logic [31:0] era, input logic ub, input logic [31:0] bv);
    return {etrn, excp, ec, 9'd0, era, ub, bv};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge (caller ensures in_ready=1)
  task automatic send(input logic [31:0] pc, input logic [4:0] fl, input logic [31:0] bv, input logic er);
    in_valid = 1'b1;
    in_pc    = pc;
    in_flags = fl;
    in_badv  = bv;
    in_ertn  = er;
    step();
    in_valid = 1'b0;
    in_flags = 5'd0;
    in_ertn  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = 32'd0; in_flags = 5'd0; in_badv = 32'd0;
    in_ertn = 1'b0; have_intrpt = 1'b0; excp_jump = 1'b0; excp_pc = 32'd0; redirect_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", 82'(in_ready), 82'd0);
    chk("rst_flush",    82'(flush), 82'd0);
    chk("rst_rvalid",   82'(redirect_valid), 82'd0);
    chk("rst_csr_bus",  csr_bus, 82'd0);
    #9 rst_n = 1'b1;
    #1 chk("rel_in_ready_pre", 82'(in_ready), 82'd0);
    step();
    chk("rel_in_ready_post", 82'(in_ready), 82'd1);

    // SYS exception, redirect held for 3 cycles
    send(32'h1c000100, F_SYS, 32'h0, 1'b0);
    chk("sys_bus",      csr_bus, bus(1'b0, 1'b1, 6'h0B, 32'h1c000100, 1'b0, 32'h0));
    chk("sys_flush",    82'(flush), 82'd1);
    chk("sys_in_ready", 82'(in_ready), 82'd0);
    excp_jump = 1'b1; excp_pc = 32'h1c008000;
    step();
    excp_jump = 1'b0; excp_pc = 32'hdeadbeef;
    chk("sys_bus_gone", csr_bus, 82'd0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_rvalid", 82'(redirect_valid), 82'd1);
      chk("hold_rpc",    82'(redirect_pc), 82'(32'h1c008000));
      chk("hold_flush",  82'(flush), 82'd1);
      step();
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("rdy_rvalid",   82'(redirect_valid), 82'd0);
    chk("rdy_flush",    82'(flush), 82'd0);
    chk("rdy_in_ready", 82'(in_ready), 82'd1);

    // INE beats ALE; then CSR refuses the jump
    send(32'h1c000110, F_INE | F_ALE, 32'h3, 1'b0);
    chk("ine_bus", csr_bus, bus(1'b0, 1'b1, 6'h0D, 32'h1c000110, 1'b0, 32'h0));
    step();
    chk("nojmp_flush",    82'(flush), 82'd0);
    chk("nojmp_rvalid",   82'(redirect_valid), 82'd0);
    chk("nojmp_in_ready", 82'(in_ready), 82'd1);
    chk("nojmp_bus",      csr_bus, 82'd0);

    // ALE alone reports badv; interrupt pulsed during REDIRECT
    send(32'h1c000120, F_ALE, 32'h3, 1'b0);
    chk("ale_bus", csr_bus, bus(1'b0, 1'b1, 6'h09, 32'h1c000120, 1'b1, 32'h3));
    excp_jump = 1'b1; excp_pc = 32'h300;
    step();
    excp_jump = 1'b0;
    chk("ale_rpc", 82'(redirect_pc), 82'(32'h300));
    have_intrpt = 1'b1;
    step();
    have_intrpt = 1'b0;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    send(32'h200, 5'd0, 32'h55, 1'b0);
    chk("int_bus", csr_bus, bus(1'b0, 1'b1, 6'h00, 32'h200, 1'b0, 32'h0));
    step();
    // Interrupt consumed: a clean instruction now retires quietly
    send(32'h204, 5'd0, 32'h0, 1'b0);
    chk("clean_in_ready", 82'(in_ready), 82'd1);
    chk("clean_flush",    82'(flush), 82'd0);
    chk("clean_bus",      csr_bus, 82'd0);

    // ertn with no flags
    send(32'h1c000130, 5'd0, 32'h0, 1'b1);
    chk("ertn_etrn", 82'(csr_bus[81]), 82'd1);
    chk("ertn_excp", 82'(csr_bus[80]), 82'd0);
    chk("ertn_ubadv", 82'(csr_bus[32]), 82'd0);
    excp_jump = 1'b1; excp_pc = 32'h400;
    step();
    excp_jump = 1'b0;
    chk("ertn_rpc", 82'(redirect_pc), 82'(32'h400));
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;

    // ertn with BRK: exception wins
    send(32'h1c000140, F_BRK, 32'h0, 1'b1);
    chk("ertn_brk_bus", csr_bus, bus(1'b0, 1'b1, 6'h0C, 32'h1c000140, 1'b0, 32'h0));
    step();

    // ADEF beats SYS and ALE
    send(32'h1c000150, F_ADEF | F_SYS | F_ALE, 32'hcafe0001, 1'b0);
    chk("adef_bus", csr_bus, bus(1'b0, 1'b1, 6'h08, 32'h1c000150, 1'b1, 32'hcafe0001));
    excp_jump = 1'b1; excp_pc = 32'h500;
    step();
    excp_jump = 1'b0;
    chk("mid_rvalid", 82'(redirect_valid), 82'd1);

    // Reset asserted mid-REDIRECT
    rst_n = 1'b0;
    #1;
    chk("mrst_flush",    82'(flush), 82'd0);
    chk("mrst_rvalid",   82'(redirect_valid), 82'd0);
    chk("mrst_bus",      csr_bus, 82'd0);
    chk("mrst_in_ready", 82'(in_ready), 82'd0);
    #2 rst_n = 1'b1;
    #1 chk("mrst_rel_pre", 82'(in_ready), 82'd0);
    step();
    chk("mrst_rel_post", 82'(in_ready), 82'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/excp_arb.md
Name: excp_arb

Overview:
- Commit-side exception arbiter; sits directly upstream of the CSR file.
- Accepts one retiring instruction per handshake, together with its exception flags, and latches pending interrupts.
- Picks the highest-priority cause, drives a one-cycle csr_bus pulse to the CSR file, and samples the returned excp_pc.
- Holds the pipeline flush and the fetch redirect until the fetch stage accepts the redirect.

Parameters:
CSR_BUS_WD, 82, csr_bus width = is_etrn(1), in_excp(1), ecode(6), subecode(9), era(32), use_badv(1), badv(32), packed MSB-first in that order.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  retiring instruction valid
in_ready  out  1  arbiter can accept an instruction
in_pc  in  32  pc of the instruction
in_flags  in  5  {adef, ine, sys, brk, ale}
in_badv  in  32  faulting address for adef/ale
in_ertn  in  1  instruction is ertn
have_intrpt  in  1  interrupt pending, from the CSR file
csr_bus  out  CSR_BUS_WD  exception bus to the CSR file
excp_jump  in  1  CSR file accepted the jump
excp_pc  in  32  jump target from the CSR file
flush  out  1  kill all younger pipeline state
redirect_valid  out  1  fetch redirect request
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepted the redirect

Behaviour:
- Reset (async, on rst_n low, any state, mid-operation included):
  - state=IDLE, all outputs 0, in_ready=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- States: IDLE, ISSUE, REDIRECT.
- IDLE:
  - in_ready=1.
  - Transfer occurs when in_valid&in_ready. On a transfer:
    - int_pend: sticky latch; set whenever have_intrpt=1 in any state; cleared when an INT is issued.
    - Cause priority: INT(int_pend|have_intrpt) > ADEF > INE > SYS > BRK > ALE.
    - Ecodes: INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D; subecode always 0.
    - If any cause: register era=in_pc, ecode, in_excp=1, is_etrn=0, use_badv=1 only for ADEF/ALE (badv=in_badv, else badv=0). Go to ISSUE.
    - Else if in_ertn: is_etrn=1, in_excp=0, use_badv=0. Go to ISSUE.
    - Else: the instruction retires normally; stay in IDLE; csr_bus stays 0.
  - An interrupt is never issued without a transfer; it is attached to the next transferred instruction, and era = that pc.
- ISSUE (exactly 1 cycle):
  - csr_bus = the registered fields.
  - flush=1, in_ready=0.
  - If excp_jump=1: latch redirect_pc=excp_pc, go to REDIRECT.
  - If excp_jump=0 (CSR write conflict): clear csr_bus, go to IDLE, no redirect; flush still pulses this one cycle.
- REDIRECT:
  - csr_bus=0, flush=1, redirect_valid=1, in_ready=0.
  - redirect_pc is stable while redirect_valid=1 && !redirect_ready.
  - On redirect_ready: go to IDLE; flush and redirect_valid drop the next cycle.
- Exception latency: transfer edge -> csr_bus valid the next cycle -> redirect_valid the cycle after.
- csr_bus is a strict single-cycle pulse per exception/ertn; it is never asserted in IDLE or REDIRECT.
- Boundary cases:
  - in_valid with no flags and no interrupt: no state change.
  - Multiple flags set: only the top-priority cause is reported.
  - ertn with a flag set: the exception wins and is_etrn=0.
  - have_intrpt asserted during ISSUE/REDIRECT: latched into int_pend, not lost.

Test Plan:
- Reset mid-REDIRECT: rst_n=0 -> same cycle flush=0, redirect_valid=0, csr_bus=0; after release, in_ready=1 at the next edge.
- in_pc=0x1c000100, flags=sys -> csr_bus in_excp=1, ecode=0x0B, era=0x1c000100, use_badv=0 for 1 cycle. Then excp_jump=1 with excp_pc=0x1c008000 -> redirect_valid, redirect_pc=0x1c008000. Hold redirect_ready=0 for 3 cycles -> stable; ready=1 -> IDLE.
- flags=ine|ale, in_badv=0x3 -> ecode=0x0D, use_badv=0, badv=0; flags=ale only -> ecode=0x09, use_badv=1, badv=0x3.
- have_intrpt pulsed 1 cycle in REDIRECT, then a clean instruction at pc 0x200 transferred -> ecode=0x00, era=0x200; int_pend cleared.
- in_ertn=1, no flags -> is_etrn=1, in_excp=0; excp_jump=1, excp_pc=0x400 -> redirect_pc=0x400.
- ISSUE with excp_jump=0 -> 1-cycle flush, no redirect_valid, back to IDLE with in_ready=1.
